// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
interface uart_rx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;

   // Receiver drives the byte and status flags; the consumer drives ready.
   modport master (output data, valid, frame_err, overrun, input ready);
   modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a bit timer that restarts on each
// start edge, byte delivered on a valid/ready handshake with error pulses.
module uart_rx #(
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rx,
   output logic      busy,
   uart_rx_if.master bus
);

   localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
   localparam int unsigned HALF    = BIT_CYC / 2;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned IDX_W   = 3;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] bit_idx;
   logic [7:0]       shift;
   logic             rx_meta;
   logic             rx_s;

   logic [7:0]       data;
   logic             valid;
   logic             frame_err;
   logic             overrun;

   assign bus.data      = data;
   assign bus.valid     = valid;
   assign bus.frame_err = frame_err;
   assign bus.overrun   = overrun;

   // Two-flop synchronizer for the asynchronous serial line, idling high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM, bit timer, shift register and output handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // Consumer take; a byte loaded on this same edge overrides below.
         if (valid && bus.ready) begin
            valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     // Line went back high before mid-start: a glitch.
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (cnt == BIT_LAST) begin
                  shift   <= {rx_s, shift[7:1]};
                  cnt     <= '0;
                  bit_idx <= bit_idx + IDX_W'(1);
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     data  <= shift;
                     valid <= 1'b1;
                     if (valid && !bus.ready) begin
                        overrun <= 1'b1;
                     end
                     // Leave at mid-stop so an immediate next start is seen.
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BRK;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            BRK: begin
               // Wait out a held-low line; only one frame_err per break.
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BIT_CYC=16, HALF=8 (byte latency 154).
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 1600;
   localparam int unsigned BAUD     = 100;
   localparam int unsigned BIT_CYC  = 16;
   localparam int unsigned LAT      = 154;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic busy;

   uart_rx_if bus ();

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .rx   (rx),
      .busy (busy),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   // Rising-edge count, used to time latency from R0.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Accumulates per-cycle activity seen at the falling edge.
   int   n_valid    = 0;
   int   n_ferr     = 0;
   int   n_ovr      = 0;
   int   n_busy     = 0;
   int   valid_rise = 0;
   logic valid_d    = 1'b0;
   always @(negedge clk) begin
      if (bus.valid)     n_valid = n_valid + 1;
      if (bus.frame_err) n_ferr  = n_ferr + 1;
      if (bus.overrun)   n_ovr   = n_ovr + 1;
      if (busy)          n_busy  = n_busy + 1;
      if (bus.valid && !valid_d) valid_rise = cyc;
      valid_d = bus.valid;
   end

   int errors = 0;
   int checks = 0;
   int b_v, b_f, b_o, b_b, s0;
   logic [7:0] got [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_v = n_valid;
      b_f = n_ferr;
      b_o = n_ovr;
      b_b = n_busy;
   endtask

   // Drives one 8N1 frame starting at a falling edge; the line is left at the stop value.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      rx = stop;
      repeat (BIT_CYC) @(negedge clk);
   endtask

   initial begin
      bus.ready = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",  32'(bus.data), 32'h00);
      check("rst_valid", 32'(bus.valid), 32'h0);
      check("rst_ferr",  32'(bus.frame_err), 32'h0);
      check("rst_ovr",   32'(bus.overrun), 32'h0);
      check("rst_busy",  32'(busy), 32'h0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // Single frame 0xA5 with ready held high.
      bus.ready = 1'b1;
      snap();
      s0 = cyc + 1;
      send_frame(8'hA5, 1'b1);
      repeat (4) @(negedge clk);
      check("s1_latency", 32'(valid_rise - s0), 32'(LAT));
      check("s1_valid_cycles", 32'(n_valid - b_v), 32'd1);
      check("s1_data", 32'(bus.data), 32'hA5);
      check("s1_ferr", 32'(n_ferr - b_f), 32'd0);
      check("s1_ovr",  32'(n_ovr - b_o), 32'd0);

      // Back-to-back 0x00 then 0xFF, ready pulsed after each valid.
      bus.ready = 1'b0;
      repeat (4) @(negedge clk);
      snap();
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
         end
         begin
            for (int k = 0; k < 2; k++) begin
               for (int t = 0; t < 400 && !bus.valid; t++) @(negedge clk);
               got[k] = bus.data;
               bus.ready = 1'b1;
               @(negedge clk);
               bus.ready = 1'b0;
            end
         end
      join
      repeat (4) @(negedge clk);
      check("s2_byte0", 32'(got[0]), 32'h00);
      check("s2_byte1", 32'(got[1]), 32'hFF);
      check("s2_valid_cycles", 32'(n_valid - b_v), 32'd2);
      check("s2_ferr", 32'(n_ferr - b_f), 32'd0);
      check("s2_ovr",  32'(n_ovr - b_o), 32'd0);

      // Five-cycle low glitch is rejected at E0+8.
      repeat (10) @(negedge clk);
      snap();
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      check("s3_busy_cycles", 32'(n_busy - b_b), 32'd8);
      check("s3_busy_end", 32'(busy), 32'h0);
      check("s3_valid", 32'(n_valid - b_v), 32'd0);
      check("s3_ferr",  32'(n_ferr - b_f), 32'd0);
      check("s3_ovr",   32'(n_ovr - b_o), 32'd0);

      // Bad stop bit followed by a held-low break, then a good frame.
      bus.ready = 1'b1;
      snap();
      send_frame(8'h3C, 1'b0);
      repeat (40) @(negedge clk);
      check("s4_ferr_once", 32'(n_ferr - b_f), 32'd1);
      check("s4_no_valid", 32'(n_valid - b_v), 32'd0);
      check("s4_busy_brk", 32'(busy), 32'h1);
      rx = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
      send_frame(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      check("s4_data", 32'(bus.data), 32'h3C);
      check("s4_valid_cycles", 32'(n_valid - b_v), 32'd1);
      check("s4_ferr_total", 32'(n_ferr - b_f), 32'd1);

      // Overrun: two bytes with ready low.
      bus.ready = 1'b0;
      repeat (4) @(negedge clk);
      snap();
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (4) @(negedge clk);
      check("s5_ovr", 32'(n_ovr - b_o), 32'd1);
      check("s5_data", 32'(bus.data), 32'h22);
      check("s5_valid", 32'(bus.valid), 32'h1);
      check("s5_ferr", 32'(n_ferr - b_f), 32'd0);
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      check("s5_valid_cleared", 32'(bus.valid), 32'h0);
      check("s5_data_kept", 32'(bus.data), 32'h22);

      // Reset in the middle of data bit 3, then frame 0x5A.
      repeat (10) @(negedge clk);
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         repeat (BIT_CYC) @(negedge clk);
      end
      rx = 1'b0;
      repeat (BIT_CYC / 2) @(negedge clk);
      check("s6_busy_pre", 32'(busy), 32'h1);
      rst = 1'b0;
      rx  = 1'b1;
      @(negedge clk);
      check("s6_rst_data",  32'(bus.data), 32'h00);
      check("s6_rst_valid", 32'(bus.valid), 32'h0);
      check("s6_rst_busy",  32'(busy), 32'h0);
      check("s6_rst_ferr",  32'(bus.frame_err), 32'h0);
      check("s6_rst_ovr",   32'(bus.overrun), 32'h0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("s6_post_busy", 32'(busy), 32'h0);
      check("s6_post_data", 32'(bus.data), 32'h00);
      bus.ready = 1'b1;
      snap();
      send_frame(8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      check("s6_data", 32'(bus.data), 32'h5A);
      check("s6_valid_cycles", 32'(n_valid - b_v), 32'd1);
      check("s6_ferr", 32'(n_ferr - b_f), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case the sequence stalls.
   initial begin
      #300000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous UART receiver for 8N1 frames on the 100 MHz system clock. It samples the serial line at mid-bit using its own bit-timing counter, which restarts on every start edge so it stays in phase with the incoming frame. Received bytes are presented on a valid/ready output handshake, with single-cycle framing-error and overrun flags. It is the receive-side counterpart of the baud-tick generator and transmitter in the UART design.

## Interface
- CLK_FREQ, 100000000, system clock frequency in Hz
- BAUD, 9600, line rate in bit/s; BIT_CYC = CLK_FREQ/BAUD (integer division), HALF = BIT_CYC/2; legal range 4 ≤ BIT_CYC ≤ 65535
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- rx  input  1  serial line, idle high, asynchronous to clk
- data  output  8  received byte, LSB = first data bit
- valid  output  1  data holds an unconsumed byte
- ready  input  1  consumer accepts data when valid & ready on a rising edge
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: unconsumed byte overwritten
- busy  output  1  high in any state other than IDLE

## Operation
- Synchronizer: two flops on rx, both reset to 1; rx_s is the second-flop output. Only rx_s is used internally.
- Counter cnt is 16 bits wide. bit_idx is 3 bits wide. shift is an 8-bit register that shifts right, loading the new bit into bit 7.
- State IDLE:
  - rx_s==0 → START, cnt←0.
- State START:
  - cnt increments.
  - At cnt==HALF-1, if rx_s==1 → IDLE (glitch rejected, no flags raised).
  - At cnt==HALF-1, if rx_s==0 → DATA, cnt←0, bit_idx←0.
- State DATA:
  - cnt increments.
  - At cnt==BIT_CYC-1: shift←{rx_s, shift[7:1]}, cnt←0, bit_idx increments.
  - After the sample with bit_idx==7 → STOP.
- State STOP:
  - At cnt==BIT_CYC-1, if rx_s==1: data←shift, valid←1 → IDLE. If valid was already 1 and ready is low on this edge, overrun pulses and the old byte is lost.
  - At cnt==BIT_CYC-1, if rx_s==0: frame_err pulses, data and valid are unchanged → BREAK.
- State BREAK:
  - Stay until rx_s==1, then → IDLE.
  - A held-low line (break) produces exactly one frame_err.
- Return to IDLE happens at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- Handshake:
  - valid clears on the edge where valid & ready, unless a new byte loads on the same edge.
  - If a byte loads while valid & ready: valid stays 1, data takes the new byte, no overrun.
  - data is stable while valid is high and no new load occurs.
- Reset, at any time: all state returns to the values below; a partially received frame is discarded with no flags.
  - State IDLE, cnt 0, bit_idx 0, shift 0x00, synchronizer flops 1.
  - Outputs: data 0x00, valid 0, frame_err 0, overrun 0, busy 0.

## Timing
- Edge numbering: R0 is the first rising edge at which rx is low.
  - rx_s is low at edge R2 (= E0), and the state enters START at E0.
- Start bit is checked at edge E0+HALF.
- Data bit i (i = 0..7) is sampled at edge E0+HALF+(i+1)·BIT_CYC.
- Stop bit is sampled at edge E0+HALF+9·BIT_CYC.
  - valid, frame_err and overrun are visible after this edge.
- Latency from R0 to valid = 2+HALF+9·BIT_CYC cycles.
  - Default parameters: 2+5208+93744 = 98954 cycles.
- frame_err and overrun are high for exactly one cycle each.
- busy is high from E0 through the stop-sample edge, and for all cycles spent in BREAK.

## Test plan
All scenarios use CLK_FREQ=1600 and BAUD=100, giving BIT_CYC=16, HALF=8, and a byte latency of 154 cycles.
- Single frame 0xA5 with ready held high → valid for exactly 1 cycle, 154 cycles after R0, with data=0xA5; frame_err=0 and overrun=0 throughout.
- Frames 0x00 then 0xFF back-to-back, no idle gap, with ready pulsed after each valid → both bytes received in order, no flags.
- rx low for 5 cycles, then high → busy pulses, returns to IDLE at E0+8; valid, frame_err and overrun all stay 0.
- Frame 0x3C with stop bit driven 0, then line held low for 40 cycles, then a valid frame 0x3C → exactly one frame_err pulse and no valid for the first frame; the second frame yields data=0x3C.
- ready held low; send 0x11 then 0x22 → one overrun pulse at the second stop sample, data=0x22, valid stays 1; asserting ready then clears valid.
- rst asserted during data bit 3 of a frame, released, then frame 0x5A sent → all outputs at reset values during and after reset; the next frame receives correctly with data=0x5A.
